// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring), one step per cycle, 34-cycle issue interval.
// Define MULTDIV_DIV_EN to build the divider; without it a DIV start faults (result 0, exception 1) after one cycle.
module multdiv_iter #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [CNT_BITS-1:0] count;
  logic                op_div;

  // Booth accumulator layout: {hi, lo, q-1}; lo starts as the multiplier.
  logic [2*WIDTH:0]    acc;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH:0]      booth_sum;
  logic [2*WIDTH:0]    booth_next;
  logic [2*WIDTH-1:0]  product;
  logic                mul_ovf;

  // hi is sign-extended to WIDTH+1 so adding/subtracting the most negative multiplicand cannot overflow
  always_comb begin
    booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    endcase
    booth_next = {booth_sum, acc[WIDTH:1]};
  end

  assign product = acc[2*WIDTH:1];
  assign mul_ovf = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));

`ifdef MULTDIV_DIV_EN
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic             q_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_next, quo_next;

  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    if (diff[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state          <= IDLE;
      count          <= '0;
      op_div         <= 1'b0;
      acc            <= '0;
      mcand          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef MULTDIV_DIV_EN
      rem            <= '0;
      quo            <= '0;
      dvsr           <= '0;
      q_neg          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_MULT) begin
            state  <= MUL;
            busy   <= 1'b1;
            count  <= '0;
            op_div <= 1'b0;
            acc    <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            mcand  <= data_operandA;
          end else if (ctrl_DIV) begin
            busy   <= 1'b1;
            op_div <= 1'b1;
`ifdef MULTDIV_DIV_EN
            state    <= DIV;
            count    <= '0;
            rem      <= '0;
            quo      <= mag_a;
            dvsr     <= mag_b;
            q_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
`else
            state    <= DONE;
`endif
          end
        end
        MUL: begin
          acc   <= booth_next;
          count <= count + 1'b1;
          if (count == CNT_BITS'(WIDTH-1)) state <= DONE;
        end
`ifdef MULTDIV_DIV_EN
        DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 1'b1;
          if (count == CNT_BITS'(WIDTH-1)) state <= DONE;
        end
`endif
        DONE: begin
          state          <= IDLE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b1;
          if (op_div) begin
`ifdef MULTDIV_DIV_EN
            if (div_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else begin
              data_result    <= q_neg ? -quo : quo;
              data_exception <= div_ovf;
            end
`else
            data_result    <= '0;
            data_exception <= 1'b1;
`endif
          end else begin
            data_result    <= product[WIDTH-1:0];
            data_exception <= mul_ovf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
